// File: rtl/aes_seq_ctrl.sv
// Sequencer between the UART command machine and the AES core: key load, block run, and
// MSB-first byte streaming of the result. Define AES_STATUS_HDR_EN to prefix a status header byte.
module aes_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned DATA_W         = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rst_sw,
    input  logic              key_ready,
    input  logic [DATA_W-1:0] kin,
    input  logic              din_ready,
    input  logic [DATA_W-1:0] din,
    input  logic              start,
    input  logic              enc_dec,
    output logic [DATA_W-1:0] aes_key,
    output logic              aes_key_load,
    input  logic              aes_key_done,
    output logic [DATA_W-1:0] aes_din,
    output logic              aes_start,
    output logic              aes_enc_dec,
    input  logic              aes_done,
    input  logic [DATA_W-1:0] aes_dout,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              key_valid,
    output logic [2:0]        err_flags
);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY_LOAD, S_WAIT_KEY, S_RUN, S_WAIT_DONE, S_SEND
    } state_t;

    // Abort fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 2);

    state_t            state_q;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] result_q;
    logic              enc_dec_q;
    logic              key_load_q;
    logic              start_q;
    logic [3:0]        idx_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic              key_valid_q;
    logic [2:0]        err_q;
    logic [15:0]       cnt_q;
    logic              kd_prev_q;

    logic drop;
    logic key_rise;
    logic to_hit;
    logic beat;

    assign drop     = (state_q != S_IDLE) && (key_ready || din_ready || start);
    assign key_rise = aes_key_done && !kd_prev_q;
    assign to_hit   = (cnt_q == TO_LAST);
    assign beat     = tx_valid_q && tx_ready;

`ifdef AES_STATUS_HDR_EN
    logic       hdr_q;
    logic [2:0] err_now;
    logic [7:0] hdr_byte;

    assign err_now  = err_q | {drop, 2'b00};
    assign hdr_byte = (err_now == 3'b000) ? 8'hA5 : {5'b11100, err_now};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            din_q       <= '0;
            result_q    <= '0;
            enc_dec_q   <= 1'b0;
            key_load_q  <= 1'b0;
            start_q     <= 1'b0;
            idx_q       <= 4'd15;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            key_valid_q <= 1'b0;
            err_q       <= 3'b000;
            cnt_q       <= 16'd0;
            kd_prev_q   <= 1'b0;
`ifdef AES_STATUS_HDR_EN
            hdr_q       <= 1'b0;
`endif
        end else if (rst_sw) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            din_q       <= '0;
            result_q    <= '0;
            enc_dec_q   <= 1'b0;
            key_load_q  <= 1'b0;
            start_q     <= 1'b0;
            idx_q       <= 4'd15;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            key_valid_q <= 1'b0;
            err_q       <= 3'b000;
            cnt_q       <= 16'd0;
            kd_prev_q   <= 1'b0;
`ifdef AES_STATUS_HDR_EN
            hdr_q       <= 1'b0;
`endif
        end else begin
            kd_prev_q  <= aes_key_done;
            key_load_q <= 1'b0;
            start_q    <= 1'b0;
            if (drop)
                err_q[2] <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (din_ready)
                        din_q <= din;
                    if (key_ready) begin
                        key_q       <= kin;
                        key_valid_q <= 1'b0;
                        key_load_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_KEY_LOAD;
                    end else if (start) begin
                        if (key_valid_q) begin
                            enc_dec_q <= enc_dec;
                            start_q   <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= S_RUN;
                        end else begin
                            err_q[0] <= 1'b1;
                        end
                    end
                end

                S_KEY_LOAD: begin
                    cnt_q   <= 16'd0;
                    state_q <= S_WAIT_KEY;
                end

                S_WAIT_KEY: begin
                    if (key_rise) begin
                        key_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else if (to_hit) begin
                        err_q[1] <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                S_RUN: begin
                    cnt_q   <= 16'd0;
                    state_q <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    if (aes_done) begin
                        result_q   <= aes_dout;
                        idx_q      <= 4'd15;
                        tx_valid_q <= 1'b1;
`ifdef AES_STATUS_HDR_EN
                        hdr_q      <= 1'b1;
                        tx_data_q  <= hdr_byte;
`else
                        tx_data_q  <= aes_dout[DATA_W-1 -: 8];
`endif
                        state_q    <= S_SEND;
                    end else if (to_hit) begin
                        err_q[1] <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                S_SEND: begin
                    // tx_data only moves on an accepted beat, so it holds through stalls.
                    if (beat) begin
`ifdef AES_STATUS_HDR_EN
                        if (hdr_q) begin
                            hdr_q     <= 1'b0;
                            tx_data_q <= result_q[DATA_W-1 -: 8];
                        end else
`endif
                        if (idx_q == 4'd0) begin
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            idx_q     <= idx_q - 4'd1;
                            tx_data_q <= result_q[{idx_q - 4'd1, 3'b000} +: 8];
                        end
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign aes_key      = key_q;
    assign aes_key_load = key_load_q;
    assign aes_din      = din_q;
    assign aes_start    = start_q;
    assign aes_enc_dec  = enc_dec_q;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign busy         = busy_q;
    assign key_valid    = key_valid_q;
    assign err_flags    = err_q;

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Directed bench for aes_seq_ctrl: per-cycle vector table for key load, plus run/stall/timeout/reset sequences.
module tb_aes_seq_ctrl;

    localparam logic [127:0] KIN  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] DIN  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] DOUT = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

    logic         clk = 1'b0;
    logic         rst_n, rst_sw, key_ready, din_ready, start, enc_dec;
    logic [127:0] kin, din, aes_key, aes_din, aes_dout;
    logic         aes_key_load, aes_key_done, aes_start, aes_enc_dec, aes_done;
    logic [7:0]   tx_data;
    logic         tx_valid, tx_ready, busy, key_valid;
    logic [2:0]   err_flags;

    int errors = 0;
    int checks = 0;

    aes_seq_ctrl #(.TIMEOUT_CYCLES(8), .DATA_W(128)) dut (
        .clk(clk), .rst_n(rst_n), .rst_sw(rst_sw),
        .key_ready(key_ready), .kin(kin), .din_ready(din_ready), .din(din),
        .start(start), .enc_dec(enc_dec),
        .aes_key(aes_key), .aes_key_load(aes_key_load), .aes_key_done(aes_key_done),
        .aes_din(aes_din), .aes_start(aes_start), .aes_enc_dec(aes_enc_dec),
        .aes_done(aes_done), .aes_dout(aes_dout),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .key_valid(key_valid), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       kr, dr, st, kd, dn;
        logic [7:0] exp;   // {busy, key_load, aes_start, key_valid, tx_valid, err[2:0]}
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        logic [127:0] d;
        d = DOUT;
        return d[127 - 8*k -: 8];
    endfunction

    initial begin
        int           n;
        logic         saw_tv, stalled;
        logic [7:0]   held;

        vecs[0]  = '{kr:0, dr:0, st:1, kd:0, dn:0, exp:8'b00000_001};
        vecs[1]  = '{kr:0, dr:0, st:0, kd:0, dn:0, exp:8'b00000_001};
        vecs[2]  = '{kr:1, dr:1, st:0, kd:0, dn:0, exp:8'b11000_001};
        vecs[3]  = '{kr:0, dr:0, st:0, kd:0, dn:0, exp:8'b10000_001};
        vecs[4]  = '{kr:0, dr:0, st:0, kd:0, dn:0, exp:8'b10000_001};
        vecs[5]  = '{kr:0, dr:0, st:0, kd:0, dn:0, exp:8'b10000_001};
        vecs[6]  = '{kr:0, dr:0, st:0, kd:0, dn:0, exp:8'b10000_001};
        vecs[7]  = '{kr:0, dr:0, st:0, kd:0, dn:0, exp:8'b10000_001};
        vecs[8]  = '{kr:0, dr:0, st:0, kd:1, dn:0, exp:8'b00010_001};
        vecs[9]  = '{kr:0, dr:0, st:0, kd:1, dn:0, exp:8'b00010_001};
        vecs[10] = '{kr:0, dr:0, st:0, kd:0, dn:1, exp:8'b00010_001};
        vecs[11] = '{kr:0, dr:0, st:0, kd:0, dn:0, exp:8'b00010_001};

        rst_n = 1'b0; rst_sw = 1'b0; key_ready = 1'b0; din_ready = 1'b0; start = 1'b0;
        enc_dec = 1'b0; kin = KIN; din = DIN; aes_key_done = 1'b0; aes_done = 1'b0;
        aes_dout = DOUT; tx_ready = 1'b0;
        tick();
        tick();
        chk("reset_ctl", {busy, aes_key_load, aes_start, key_valid, tx_valid, err_flags, tx_data, aes_enc_dec},
            '0);
        chk("reset_key", aes_key, '0);
        chk("reset_din", aes_din, '0);
        rst_n = 1'b1;
        tick();

        // Key load with a start-without-key error first.
        for (int i = 0; i < 12; i++) begin
            key_ready = vecs[i].kr; din_ready = vecs[i].dr; start = vecs[i].st;
            aes_key_done = vecs[i].kd; aes_done = vecs[i].dn;
            tick();
            chk($sformatf("vec%0d", i),
                {busy, aes_key_load, aes_start, key_valid, tx_valid, err_flags}, vecs[i].exp);
        end
        key_ready = 1'b0; din_ready = 1'b0; start = 1'b0; aes_key_done = 1'b0; aes_done = 1'b0;
        chk("key_latched", aes_key, KIN);
        chk("din_latched", aes_din, DIN);

        // Encrypt run, sink always ready.
        tx_ready = 1'b1;
        start = 1'b1; enc_dec = 1'b0;
        tick();
        start = 1'b0;
        chk("run_start", {aes_start, busy, aes_enc_dec}, 3'b110);
        tick();
        chk("run_start_1cyc", aes_start, 1'b0);
        tick();
        tick();
        aes_done = 1'b1;
        tick();
        aes_done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("byte%0d", k), {tx_valid, tx_data}, {1'b1, exp_byte(k)});
            tick();
        end
        chk("run_end", {tx_valid, busy}, 2'b00);

        // Decrypt run with a dropped start in WAIT_DONE, then a stalling sink.
        tx_ready = 1'b0;
        start = 1'b1; enc_dec = 1'b1;
        tick();
        start = 1'b0; enc_dec = 1'b0;
        chk("dec_start", {aes_start, aes_enc_dec}, 2'b11);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("drop_err", {busy, aes_enc_dec, err_flags}, 5'b11_101);
        aes_done = 1'b1;
        tick();
        aes_done = 1'b0;
        n = 0;
        for (int c = 0; c < 64 && n < 16; c++) begin
            tx_ready = (c % 2 == 0);
            stalled = 1'b0;
            held = 8'h00;
            if (tx_valid) begin
                if (tx_ready) begin
                    chk($sformatf("stall_byte%0d", n), tx_data, exp_byte(n));
                    n++;
                end else begin
                    held = tx_data;
                    stalled = 1'b1;
                end
            end
            tick();
            if (stalled)
                chk("stall_hold", {tx_valid, tx_data}, {1'b1, held});
        end
        chk("stall_count", n, 16);
        chk("stall_end", {tx_valid, busy}, 2'b00);

        // Block timeout: core never answers.
        tx_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_start", aes_start, 1'b1);
        n = 0; saw_tv = 1'b0;
        while (busy && n < 30) begin
            tick();
            n++;
            if (tx_valid) saw_tv = 1'b1;
        end
        chk("to_cycles", n, 8);
        chk("to_no_tx", saw_tv, 1'b0);
        chk("to_err", err_flags, 3'b111);

        // Key timeout: key_valid must stay low.
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        chk("kto_load", {aes_key_load, key_valid}, 2'b10);
        n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        chk("kto_cycles", n, 8);
        chk("kto_keyvalid", key_valid, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("kto_nostart", {aes_start, busy, err_flags}, 5'b00_111);

        // Soft reset overrides a same-cycle key_ready.
        rst_sw = 1'b1; key_ready = 1'b1;
        tick();
        rst_sw = 1'b0; key_ready = 1'b0;
        chk("rstsw_ctl", {busy, aes_key_load, key_valid, err_flags}, 6'b0);
        chk("rstsw_key", aes_key, '0);
        chk("rstsw_din", aes_din, '0);

        // Async reset mid-SEND at idx=7.
        key_ready = 1'b1; din_ready = 1'b1;
        tick();
        key_ready = 1'b0; din_ready = 1'b0;
        tick();
        aes_key_done = 1'b1;
        tick();
        aes_key_done = 1'b0;
        chk("f_keyvalid", {key_valid, busy}, 2'b10);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        aes_done = 1'b1;
        tick();
        aes_done = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        tx_ready = 1'b0;
        chk("f_idx7", {tx_valid, tx_data}, {1'b1, exp_byte(8)});
        #2 rst_n = 1'b0;
        #1;
        chk("f_async_ctl", {busy, aes_key_load, aes_start, key_valid, tx_valid, err_flags, tx_data, aes_enc_dec},
            '0);
        chk("f_async_key", aes_key, '0);
        chk("f_async_din", aes_din, '0);
        #3 rst_n = 1'b1;
        tick();
        chk("f_after", {busy, key_valid, tx_valid}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
